// File: rtl/id_stage.sv
// Y86 decode stage: source/destination selection, register file with same-cycle
// writeback bypass, and the registered ID/EX boundary feeding execute.
module id_stage #(
  parameter int WORD_W = 32,
  parameter int NREG   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        icode_i,
  input  logic [3:0]        ifun_i,
  input  logic [3:0]        rA_i,
  input  logic [3:0]        rB_i,
  input  logic [WORD_W-1:0] valC_i,
  input  logic [WORD_W-1:0] valP_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic [3:0]        wb_dstE_i,
  input  logic [WORD_W-1:0] wb_valE_i,
  input  logic [3:0]        wb_dstM_i,
  input  logic [WORD_W-1:0] wb_valM_i,
  output logic              valid_o,
  output logic [3:0]        icode_o,
  output logic [3:0]        ifun_o,
  output logic [WORD_W-1:0] valA_o,
  output logic [WORD_W-1:0] valB_o,
  output logic [WORD_W-1:0] valC_o,
  output logic [3:0]        dstE_o,
  output logic [3:0]        dstM_o
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;
  localparam logic [3:0] R_ESP    = 4'h4;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam int         IDX_W    = (NREG > 1) ? $clog2(NREG) : 1;

  logic [WORD_W-1:0] regs [NREG];
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [WORD_W-1:0] val_a, val_b;

  always_comb begin
    src_a = R_NONE;
    src_b = R_NONE;
    dst_e = R_NONE;
    dst_m = R_NONE;
    if (valid_i) begin
      case (icode_i)
        I_CMOVXX, I_RMMOVL, I_OPL, I_PUSHL: src_a = rA_i;
        I_POPL, I_RET:                      src_a = R_ESP;
        default: ;
      endcase
      case (icode_i)
        I_RMMOVL, I_MRMOVL, I_OPL:           src_b = rB_i;
        I_PUSHL, I_POPL, I_CALL, I_RET:      src_b = R_ESP;
        default: ;
      endcase
      case (icode_i)
        I_CMOVXX, I_IRMOVL, I_OPL:           dst_e = rB_i;
        I_PUSHL, I_POPL, I_CALL, I_RET:      dst_e = R_ESP;
        default: ;
      endcase
      case (icode_i)
        I_MRMOVL, I_POPL:                    dst_m = rA_i;
        default: ;
      endcase
    end
  end

  // Out-of-range codes (including RNONE) must never pick up a writeback to the same code.
  function automatic logic [WORD_W-1:0] read_port(
    input logic [3:0]        src,
    input logic [WORD_W-1:0] stored
  );
    if (int'(src) >= NREG)    return '0;
    else if (src == wb_dstM_i) return wb_valM_i;
    else if (src == wb_dstE_i) return wb_valE_i;
    else                       return stored;
  endfunction

  always_comb begin
    val_b = read_port(src_b, regs[src_b[IDX_W-1:0]]);
    if (icode_i == I_CALL || icode_i == I_JXX)
      val_a = valP_i;
    else
      val_a = read_port(src_a, regs[src_a[IDX_W-1:0]]);
  end

  // The M write is issued last so it wins when both ports target one register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (int'(wb_dstE_i) < NREG) regs[wb_dstE_i[IDX_W-1:0]] <= wb_valE_i;
      if (int'(wb_dstM_i) < NREG) regs[wb_dstM_i[IDX_W-1:0]] <= wb_valM_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bubble_i || (!stall_i && !valid_i)) begin
      valid_o <= 1'b0;
      icode_o <= I_NOP;
      ifun_o  <= 4'h0;
      valA_o  <= '0;
      valB_o  <= '0;
      valC_o  <= '0;
      dstE_o  <= R_NONE;
      dstM_o  <= R_NONE;
    end else if (!stall_i) begin
      valid_o <= 1'b1;
      icode_o <= icode_i;
      ifun_o  <= ifun_i;
      valA_o  <= val_a;
      valB_o  <= val_b;
      valC_o  <= valC_i;
      dstE_o  <= dst_e;
      dstM_o  <= dst_m;
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Y86 decode stage with the architectural register file.
- Sits directly upstream of the execute stage. Takes fetched fields, selects source and destination registers, and reads operands with same-cycle writeback bypass.
- Presents icode/ifun/valA/valB/valC/dstE/dstM to execute through a registered ID/EX pipeline boundary.
- Also accepts writeback of valE/valM from later stages into the register file.

Parameters:
- WORD_W, 32, data word width (matches the codebase `WORD` width)
- NREG, 8, number of architectural registers (%eax..%edi, codes 0-7)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- valid_i  in  1  fetch presents a valid instruction this cycle
- icode_i  in  4  instruction code
- ifun_i  in  4  function code
- rA_i  in  4  register field A (0xF = RNONE)
- rB_i  in  4  register field B
- valC_i  in  WORD_W  constant word
- valP_i  in  WORD_W  next-PC value
- stall_i  in  1  hold ID/EX register
- bubble_i  in  1  load NOP bubble into ID/EX register
- wb_dstE_i  in  4  writeback destination E (0xF = none)
- wb_valE_i  in  WORD_W  writeback data E
- wb_dstM_i  in  4  writeback destination M
- wb_valM_i  in  WORD_W  writeback data M
- valid_o  out  1  ID/EX holds a real instruction
- icode_o  out  4  registered icode
- ifun_o  out  4  registered ifun
- valA_o  out  WORD_W  registered operand A
- valB_o  out  WORD_W  registered operand B
- valC_o  out  WORD_W  registered constant
- dstE_o  out  4  registered E destination
- dstM_o  out  4  registered M destination

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset: all NREG registers are set to 0. ID/EX is loaded with a bubble: valid_o=0, icode_o=NOP(1), ifun_o=0, valA_o/valB_o/valC_o=0, dstE_o=dstM_o=0xF.
- Reset mid-operation: any writeback presented in the reset cycle is discarded.
- Source and destination selection (combinational):
  - srcA = rA for CMOVXX(2), RMMOVL(4), OPL(6), PUSHL(A); ESP(4) for POPL(B), RET(9); else RNONE.
  - srcB = rB for RMMOVL, MRMOVL(5), OPL; ESP for PUSHL, POPL, CALL(8), RET; else RNONE.
  - dstE = rB for CMOVXX, IRMOVL(3), OPL; ESP for PUSHL, POPL, CALL, RET; else RNONE.
  - dstM = rA for MRMOVL, POPL; else RNONE.
  - When valid_i=0, srcA, srcB, dstE and dstM are all forced to RNONE.
- Operand read:
  - valA = valP_i for CALL and JXX(7). Otherwise valA = read(srcA).
  - valB = read(srcB).
  - read(RNONE) or read of codes 8-E returns 0.
- Bypass: a read whose source matches wb_dstM_i returns wb_valM_i. Otherwise, a match on wb_dstE_i returns wb_valE_i. Otherwise the stored register value is returned. Net effect is zero-cycle write-before-read.
- Writeback: on a clock edge with rst=0:
  - reg[wb_dstE_i] <= wb_valE_i, and reg[wb_dstM_i] <= wb_valM_i.
  - Writes only occur for codes 0-7; codes 8-F are ignored.
  - When wb_dstE_i == wb_dstM_i, valM wins.
  - Writeback proceeds regardless of stall_i/bubble_i.
- ID/EX update, in priority order: rst > bubble_i > stall_i > load.
  - bubble_i: load the reset bubble values.
  - stall_i: hold all outputs.
  - load: capture the selected fields plus valid_i.
  - A cycle with valid_i=0 loads a bubble.
  - bubble_i and stall_i both asserted: bubble_i wins.
- Latency: operands are visible at the outputs one clock after the instruction is presented.
- Arithmetic: none; no width conversion, all values pass through at WORD_W.

Test Plan:
- Reset, then present IRMOVL rB=0 (valC=0x1234) -> next cycle valid_o=1, icode_o=3, valC_o=0x1234, dstE_o=0, dstM_o=0xF.
- Writeback wb_dstE=3, valE=0xAAAA5555 in the same cycle as OPL ADDL rA=3 rB=3 -> valA_o=valB_o=0xAAAA5555 (bypass); reg3 afterwards reads 0xAAAA5555.
- wb_dstE=wb_dstM=4 with valE=0x100, valM=0x200, then read POPL -> srcA=srcB=4 yields 0x200; dstE_o=4, dstM_o=rA.
- CALL with valP=0x40, reg4=0x80 -> valA_o=0x40, valB_o=0x80, dstE_o=4.
- stall_i held 2 cycles during new inputs -> outputs unchanged. Then assert bubble_i+stall_i together -> valid_o=0, icode_o=1, dsts=0xF.
- Write reg7=0xFFFFFFFF, then assert rst for 1 cycle together with a writeback to reg2 -> all regs read 0 afterwards, including reg2.
